bp_be_dcache_resp_scoreboard: RTL

- In-order response scoreboard for dcache-level benches, synthesizable, built around a circular buffer.
- The replay side pushes the expected load data and a byte mask for each issued load.
- The DUT side presents actual responses, which are popped and compared under the mask.
- Generalises the two-entry output buffer, random yumi generator and free-running cycle limit into one block. It adds configurable depth, LFSR-driven bounded backpressure, an idle watchdog, and match/mismatch/underflow accounting.

---
 rtl/bp_be_dcache_resp_scoreboard_pkg.sv | 27 ++
 rtl/bp_be_dcache_resp_scoreboard_if.sv | 22 ++
 rtl/bp_be_scoreboard_lfsr.sv | 24 ++
 rtl/bp_be_dcache_resp_scoreboard.sv | 124 ++++++++++++
 4 files changed

// File: rtl/bp_be_dcache_resp_scoreboard_pkg.sv
// rtl/bp_be_dcache_resp_scoreboard_pkg.sv - shared types and helpers for the dcache response scoreboard
package bp_be_dcache_resp_scoreboard_pkg;

    // Fibonacci taps 16/14/13/11 expressed as state bits 15/13/12/10
    localparam logic [15:0] lfsr16_taps_lp = 16'hB400;

    // Entries are stored at the widest supported size; narrower instances zero-extend
    localparam int max_data_width_lp = 512;
    localparam int max_mask_width_lp = max_data_width_lp / 8;

    typedef struct packed {
        logic [max_data_width_lp-1:0] data;
        logic [max_mask_width_lp-1:0] mask;
    } sb_entry_s;

    function automatic logic [max_data_width_lp-1:0] expand_byte_mask(
        input logic [max_mask_width_lp-1:0] byte_mask
    );
        logic [max_data_width_lp-1:0] bit_mask;
        bit_mask = '0;
        for (int i = 0; i < max_mask_width_lp; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        return bit_mask;
    endfunction

endpackage

// File: rtl/bp_be_dcache_resp_scoreboard_if.sv
// rtl/bp_be_dcache_resp_scoreboard_if.sv - expectation and response channels of the scoreboard
interface bp_be_dcache_resp_scoreboard_if #(
    parameter int data_width_p = 64
);
    logic                      exp_v_i;
    logic [data_width_p-1:0]   exp_data_i;
    logic [data_width_p/8-1:0] exp_mask_i;
    logic                      exp_ready_o;
    logic                      resp_v_i;
    logic [data_width_p-1:0]   resp_data_i;
    logic                      resp_ready_o;

    modport master (
        output exp_v_i, exp_data_i, exp_mask_i, resp_v_i, resp_data_i,
        input  exp_ready_o, resp_ready_o
    );

    modport slave (
        input  exp_v_i, exp_data_i, exp_mask_i, resp_v_i, resp_data_i,
        output exp_ready_o, resp_ready_o
    );
endinterface

// File: rtl/bp_be_scoreboard_lfsr.sv
// rtl/bp_be_scoreboard_lfsr.sv - free-running 16-bit Fibonacci LFSR for response throttling
module bp_be_scoreboard_lfsr
    import bp_be_dcache_resp_scoreboard_pkg::*;
#(
    parameter logic [15:0] seed_p = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    output logic [15:0] state_o
);

    logic feedback;

    assign feedback = ^(state_o & lfsr16_taps_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_o <= seed_p;
        end else begin
            state_o <= {state_o[14:0], feedback};
        end
    end

endmodule

// File: rtl/bp_be_dcache_resp_scoreboard.sv
// rtl/bp_be_dcache_resp_scoreboard.sv - in-order masked-compare response scoreboard with throttle and watchdog
module bp_be_dcache_resp_scoreboard
    import bp_be_dcache_resp_scoreboard_pkg::*;
#(
    parameter int          data_width_p      = 64,
    parameter int          els_p             = 8,
    parameter int          stall_mode_p      = 1,
    parameter int          max_stall_p       = 15,
    parameter int          watchdog_cycles_p = 65535,
    parameter logic [15:0] seed_p            = 16'hACE1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        clear_i,
    bp_be_dcache_resp_scoreboard_if.slave sb_if,
    output logic [$clog2(els_p+1)-1:0]  outstanding_o,
    output logic                        mismatch_v_o,
    output logic [31:0]                 match_count_o,
    output logic [15:0]                 mismatch_count_o,
    output logic                        underflow_o,
    output logic                        timeout_o
);

    localparam int ptr_w_lp   = $clog2(els_p);
    localparam int stall_w_lp = $clog2(max_stall_p + 1);
    localparam int wd_w_lp    = $clog2(watchdog_cycles_p + 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [ptr_w_lp:0]   wptr_r, rptr_r;
    sb_entry_s           buf_r [els_p];
    sb_entry_s           entry_in, head;
    logic [stall_w_lp-1:0] stall_cnt_r, stall_next;
    logic [wd_w_lp-1:0]  wd_cnt_r, wd_next;
    logic [15:0]         lfsr_state;
    logic [14:0]         lfsr_unused;
    logic                lfsr_lsb;
    logic                full, empty, resp_ready, push, pop, underflow_evt, mismatch;

    bp_be_scoreboard_lfsr #(.seed_p(seed_p)) u_lfsr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .state_o   (lfsr_state)
    );

    assign {lfsr_unused, lfsr_lsb} = lfsr_state;

    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp])
                && (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);

    // Ready is forced once a stall run reaches max_stall_p, bounding starvation
    assign resp_ready = (stall_mode_p == 0) ? 1'b1
                      : (lfsr_lsb | (stall_cnt_r == stall_w_lp'(max_stall_p)));

    assign sb_if.exp_ready_o  = ~full;
    assign sb_if.resp_ready_o = resp_ready;
    assign outstanding_o      = $bits(outstanding_o)'(wptr_r - rptr_r);

    always_comb begin
        entry_in      = '0;
        entry_in.data = max_data_width_lp'(sb_if.exp_data_i);
        entry_in.mask = max_mask_width_lp'(sb_if.exp_mask_i);
        head          = buf_r[rptr_r[ptr_w_lp-1:0]];
        push          = sb_if.exp_v_i & ~full;
        pop           = sb_if.resp_v_i & resp_ready & ~empty;
        underflow_evt = sb_if.resp_v_i & resp_ready & empty;
        mismatch      = |((max_data_width_lp'(sb_if.resp_data_i) ^ head.data)
                          & expand_byte_mask(head.mask));

        stall_next = '0;
        if (!clear_i && sb_if.resp_v_i && !resp_ready) begin
            stall_next = stall_cnt_r + 1'b1;
        end

        wd_next = '0;
        if (!clear_i && !empty && !pop) begin
            wd_next = (wd_cnt_r == wd_w_lp'(watchdog_cycles_p)) ? wd_cnt_r : wd_cnt_r + 1'b1;
        end
    end

    // Entry storage needs no reset: the pointers alone define validity
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_r[wptr_r[ptr_w_lp-1:0]] <= entry_in;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r           <= '0;
            rptr_r           <= '0;
            stall_cnt_r      <= '0;
            wd_cnt_r         <= '0;
            mismatch_v_o     <= 1'b0;
            match_count_o    <= '0;
            mismatch_count_o <= '0;
            underflow_o      <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            if (push) wptr_r <= wptr_r + 1'b1;
            if (pop)  rptr_r <= rptr_r + 1'b1;
            stall_cnt_r <= stall_next;
            wd_cnt_r    <= wd_next;
            if (clear_i) begin
                mismatch_v_o     <= 1'b0;
                match_count_o    <= '0;
                mismatch_count_o <= '0;
                underflow_o      <= 1'b0;
                timeout_o        <= 1'b0;
            end else begin
                mismatch_v_o <= pop & mismatch;
                if (pop && !mismatch && (match_count_o != '1)) begin
                    match_count_o <= match_count_o + 1'b1;
                end
                if (pop && mismatch && (mismatch_count_o != '1)) begin
                    mismatch_count_o <= mismatch_count_o + 1'b1;
                end
                if (underflow_evt) underflow_o <= 1'b1;
                if (wd_next == wd_w_lp'(watchdog_cycles_p)) timeout_o <= 1'b1;
            end
        end
    end

endmodule
